lsu_axi_master: RTL
===================

# lsu_axi_master

Single-outstanding AXI4 manager that turns one CPU load/store request into one single-beat AXI read or write transaction and returns the data or completion. It sits between the core's LSU and the crossbar, and it drives subordinates such as the CLINT and SRAM controllers. Only one transaction is in flight at a time. Bursts are never issued.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- ID_W, 4, AXI ID width
- AXI_ID, 0, constant driven on ARID/AWID
- M_AXI_ACLK  in  1  single clock, all logic on rising edge
- M_AXI_ARESET  in  1  asynchronous, active-high reset
- req_valid / req_ready  in / out  1 / 1  CPU request handshake
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata / req_wstrb  in  DATA_W / STRB_W  store data and byte enables
- req_size  in  3  AXI size encoding (0 = byte, 1 = half, 2 = word)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  load data (full bus word, unshifted)
- rsp_err  out  1  response code was SLVERR or DECERR
- M_AXI_ARVALID/ARREADY, ARADDR/ARID/ARLEN/ARSIZE/ARBURST  out/in, out  1/1, ADDR_W/ID_W/8/3/2  read address channel
- M_AXI_RVALID/RREADY, RDATA/RRESP/RID/RLAST  in/out, in  1/1, DATA_W/2/ID_W/1  read data channel
- M_AXI_AWVALID/AWREADY, AWADDR/AWID/AWLEN/AWSIZE/AWBURST  out/in, out  1/1, ADDR_W/ID_W/8/3/2  write address channel
- M_AXI_WVALID/WREADY, WDATA/WSTRB/WLAST  out/in, out  1/1, DATA_W/STRB_W/1  write data channel
- M_AXI_BVALID/BREADY, BRESP/BID  in/out, in  1/1, 2/ID_W  write response channel

## Operation
- States are IDLE, RADDR, RDATA, WREQ, WRESP. req_ready = (state == IDLE).
- Request acceptance:
  - On req_valid & req_ready, latch addr, wdata, wstrb, size and wen.
  - Next state is RADDR if wen = 0, else WREQ.
- RADDR: ARVALID = 1. Hold ARVALID and the AR fields stable until ARREADY. On the AR handshake, go to RDATA.
- RDATA: RREADY = 1.
  - On RVALID, capture RDATA into rsp_rdata.
  - Set rsp_err = RRESP[1].
  - Pulse rsp_valid and return to IDLE.
- WREQ: AWVALID and WVALID both assert on entry.
  - Each valid deasserts independently after its own handshake; track this with aw_done and w_done flags.
  - AW and W may complete in the same cycle or in either order.
  - When both are done, go to WRESP.
- WRESP: BREADY = 1. On BVALID, set rsp_err = BRESP[1], pulse rsp_valid (rsp_rdata is unchanged) and return to IDLE.
- RRESP/BRESP of 00 or 01 both count as success, because subordinates in this design return 01.
- Constant fields:
  - ARLEN = AWLEN = 0.
  - ARBURST = AWBURST = 2'b01.
  - WLAST = 1 whenever WVALID is high.
  - ARSIZE = AWSIZE = latched size.
  - ARID = AWID = AXI_ID.
- RID, BID and RLAST are ignored.
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE and all VALID/READY outputs go to 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - aw_done = w_done = 0.
  - Address and data outputs go to 0.
  - An in-flight transaction is abandoned with no response. This is safe because subordinates share the reset.

## Timing
- All outputs are registered. No combinational path from AXI inputs to AXI outputs.
- Request accepted at edge N:
  - ARVALID (or AWVALID/WVALID) is high from cycle N+1.
  - Minimum load latency, with ARREADY and RVALID each arriving one cycle after their prerequisite: rsp_valid in cycle N+4.
- rsp_valid is high for exactly one cycle. req_ready is already high in that same cycle.
- A new request may be accepted in the rsp_valid cycle (back-to-back operation).
- RREADY is asserted in RDATA only. BREADY is asserted in WRESP only. Neither is held high in IDLE.
- A VALID, once asserted, is never withdrawn before its READY, except on reset.
- req_* inputs are ignored outside IDLE.

## Test plan
- Load 0x0200_0000:
  - Subordinate gives ARREADY after 2 cycles, then RVALID with RDATA = 0x1234_5678 and RRESP = 01.
  - Expect ARLEN = 0, ARSIZE = 2, one rsp_valid pulse, rsp_rdata = 0x1234_5678, rsp_err = 0.
- Store 0xDEAD_BEEF, wstrb 0xF, to 0x0200_0004:
  - WREADY arrives 3 cycles before AWREADY.
  - Expect WVALID to drop after its handshake while AWVALID stays high until AWREADY.
  - Expect BREADY only after both handshakes, and rsp_valid after BVALID with rsp_err = 0.
- Store with AWREADY and WREADY in the same cycle as first assertion:
  - Expect WRESP on the next cycle.
  - BRESP = 10 gives rsp_err = 1.
- Back-to-back:
  - Issue a second load in the same cycle as the first rsp_valid.
  - Expect it accepted and ARVALID high in the next cycle.
  - Load with RRESP = 11 gives rsp_err = 1.
- Hold ARREADY low for 10 cycles while changing req_*:
  - Expect ARADDR/ARVALID stable throughout and no second request accepted.
- Assert M_AXI_ARESET mid-RDATA:
  - Expect all VALID/READY and rsp outputs at 0 immediately, before the next clock.
  - Expect req_ready = 1 after reset deasserts and no spurious rsp_valid.

Source files
------------

// File: rtl/lsu_axi_master_if.sv
// AXI4 manager-side bus bundle for the LSU bridge: AR/R/AW/W/B channels.
// The master modport is the LSU bridge; the slave modport is a subordinate or crossbar port.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [ID_W-1:0]   ARID;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic [ID_W-1:0]   RID;
  logic              RLAST;

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [ID_W-1:0]   AWID;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;

  logic                WVALID;
  logic                WREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;

  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic [ID_W-1:0]   BID;

  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, input ARREADY,
    input  RVALID, RDATA, RRESP, RID, RLAST, output RREADY,
    output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, input AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, input WREADY,
    input  BVALID, BRESP, BID, output BREADY
  );

  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, output ARREADY,
    output RVALID, RDATA, RRESP, RID, RLAST, input RREADY,
    input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST, output WREADY,
    output BVALID, BRESP, BID, input BREADY
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4 manager: one LSU load/store becomes one single-beat AXI transaction.
// Every bus and response output is a flop, so no AXI input reaches an AXI output combinationally.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [2:0]        req_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  lsu_axi_master_if.master  m_axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

  state_t state_q, state_d;

  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              aw_done_q, w_done_q, aw_done_d, w_done_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [2:0]        size_q;
  logic              accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              unused_in;

  // Next state and handshake decode; AW and W complete independently in WREQ.
  always_comb begin
    state_d   = state_q;
    accept    = (state_q == IDLE) & req_valid;
    ar_hs     = arvalid_q & m_axi.ARREADY;
    r_hs      = rready_q  & m_axi.RVALID;
    aw_hs     = awvalid_q & m_axi.AWREADY;
    w_hs      = wvalid_q  & m_axi.WREADY;
    b_hs      = bready_q  & m_axi.BVALID;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q  | w_hs;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_valid) state_d = req_wen ? WREQ : RADDR;
      end
      RADDR:   if (ar_hs) state_d = RDATA;
      RDATA:   if (r_hs) state_d = IDLE;
      WREQ:    if (aw_done_d && w_done_d) state_d = WRESP;
      WRESP:   if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Channel valids/readies follow the next state so they appear in the cycle the state is entered.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      arvalid_q <= (state_d == RADDR);
      rready_q  <= (state_d == RDATA);
      awvalid_q <= (state_d == WREQ) & ~aw_done_d;
      wvalid_q  <= (state_d == WREQ) & ~w_done_d;
      bready_q  <= (state_d == WRESP);
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        size_q  <= req_size;
      end
      rsp_valid <= r_hs | b_hs;
      if (r_hs) begin
        rsp_rdata <= m_axi.RDATA;
        rsp_err   <= m_axi.RRESP[1];
      end else if (b_hs) begin
        rsp_err   <= m_axi.BRESP[1];
      end
    end
  end

  assign req_ready = (state_q == IDLE);

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARID    = ID_W'(AXI_ID);
  assign m_axi.ARLEN   = 8'd0;
  assign m_axi.ARSIZE  = size_q;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.RREADY  = rready_q;

  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWID    = ID_W'(AXI_ID);
  assign m_axi.AWLEN   = 8'd0;
  assign m_axi.AWSIZE  = size_q;
  assign m_axi.AWBURST = 2'b01;

  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.WLAST   = wvalid_q;
  assign m_axi.BREADY  = bready_q;

  // IDs, RLAST and the OKAY/EXOKAY bit carry no meaning for a single-beat, single-ID manager.
  assign unused_in = ^{m_axi.RID, m_axi.RLAST, m_axi.BID, m_axi.RRESP[0], m_axi.BRESP[0]};

endmodule
